// File: rtl/gpio_arbiter.sv
// gpio_arbiter
// Two-port round-robin arbiter that serialises single-word read/write
// commands from two requesters onto the GPIO block's single access port.
// It keeps one transaction outstanding, enforces the GPIO read latency, and
// returns the response only to the requester that owns the transaction.

module gpio_arbiter #(
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      rq_valid,
    input  logic [1:0]      rq_write,
    input  logic [2*DW-1:0] rq_wdata,
    output logic [1:0]      rq_ready,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            gp_we,
    output logic            gp_re,
    output logic [DW-1:0]   gp_wdata,
    input  logic [DW-1:0]   gp_rdata,
    output logic            busy,
    output logic            owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Read latency counter load value; the counter is wide enough for 1..15.
    localparam logic [3:0] LP_LAT = 4'(RD_LAT);

    state_t          r_state;
    state_t          w_nextState;
    logic            r_prio;
    logic            r_owner;
    logic            r_isWrite;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [3:0]      r_count;

    logic            w_grantValid;
    logic            w_grantIdx;
    logic [DW-1:0]   w_grantWdata;
    logic            w_accept;
    logic            w_capture;

    // Pick the requester to grant: on a tie the priority pointer decides,
    // otherwise the single valid requester wins. Nothing is granted while
    // reset (active-low) is asserted.
    always_comb begin
        w_grantValid = reset && (rq_valid != 2'b00);
        w_grantIdx   = 1'b0;
        if (rq_valid == 2'b11) begin
            w_grantIdx = r_prio;
        end else if (rq_valid[1]) begin
            w_grantIdx = 1'b1;
        end
        w_grantWdata = w_grantIdx ? rq_wdata[2*DW-1:DW] : rq_wdata[DW-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state and handshake/strobe outputs, all decoded from state so
    // that an asynchronous reset clears them immediately.
    always_comb begin
        w_nextState = r_state;
        rq_ready    = 2'b00;
        rsp_valid   = 2'b00;
        gp_we       = 1'b0;
        gp_re       = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_grantValid) begin
                    rq_ready[w_grantIdx] = 1'b1;
                    w_accept             = 1'b1;
                    w_nextState          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_isWrite) begin
                    gp_we       = 1'b1;
                    w_nextState = S_RESP;
                end else begin
                    gp_re       = 1'b1;
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count <= 4'd1) begin
                    w_capture   = 1'b1;
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Latch the granted command, record the owner and flip priority so the
    // other requester wins the next tie. Write data is only replaced by writes
    // so the GPIO data bus holds the last written value across reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_isWrite <= 1'b0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_owner   <= w_grantIdx;
            r_prio    <= ~w_grantIdx;
            r_isWrite <= rq_write[w_grantIdx];
            if (rq_write[w_grantIdx]) begin
                r_wdata <= w_grantWdata;
            end
        end
    end

    // Read latency counter: loaded when the read strobe goes out, counted
    // down while waiting for the GPIO read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
        end else if (r_state == S_ISSUE && !r_isWrite) begin
            r_count <= LP_LAT;
        end else if (r_state == S_WAIT) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Response data: zero for writes, GPIO read data captured on the last
    // wait cycle for reads, then held stable through the response phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (r_state == S_ISSUE && r_isWrite) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= gp_rdata;
        end
    end

    assign gp_wdata  = r_wdata;
    assign rsp_rdata = r_rdata;
    assign owner     = r_owner;

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter
// Self-checking bench for gpio_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic checked against a
// transaction-age reference model. Two instances are exercised, one with a
// read latency of 1 and one with a read latency of 3.

module tb_gpio_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstN;

    // Clock generator.
    always #5 clk = ~clk;

    logic [1:0][1:0]      rqValid;
    logic [1:0][1:0]      rqWrite;
    logic [1:0][1:0]      rspReady;
    logic [1:0][2*DW-1:0] rqWdata;
    logic [1:0][DW-1:0]   gpRdata;

    logic [1:0][1:0]      rqReadyO;
    logic [1:0][1:0]      rspValidO;
    logic [1:0][DW-1:0]   rspRdataO;
    logic [1:0][DW-1:0]   gpWdataO;
    logic [1:0]           gpWeO;
    logic [1:0]           gpReO;
    logic [1:0]           busyO;
    logic [1:0]           ownerO;
    logic [1:0][1:0]      lastReady;

    gpio_arbiter #(.DW(DW), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(rstN),
        .rq_valid(rqValid[0]), .rq_write(rqWrite[0]), .rq_wdata(rqWdata[0]),
        .rq_ready(rqReadyO[0]), .rsp_valid(rspValidO[0]), .rsp_ready(rspReady[0]),
        .rsp_rdata(rspRdataO[0]), .gp_we(gpWeO[0]), .gp_re(gpReO[0]),
        .gp_wdata(gpWdataO[0]), .gp_rdata(gpRdata[0]), .busy(busyO[0]), .owner(ownerO[0])
    );

    gpio_arbiter #(.DW(DW), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(rstN),
        .rq_valid(rqValid[1]), .rq_write(rqWrite[1]), .rq_wdata(rqWdata[1]),
        .rq_ready(rqReadyO[1]), .rsp_valid(rspValidO[1]), .rsp_ready(rspReady[1]),
        .rsp_rdata(rspRdataO[1]), .gp_we(gpWeO[1]), .gp_re(gpReO[1]),
        .gp_wdata(gpWdataO[1]), .gp_rdata(gpRdata[1]), .busy(busyO[1]), .owner(ownerO[1])
    );

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        logic [1:0]    v;
        logic [1:0]    w;
        logic [DW-1:0] wd0;
        logic [DW-1:0] wd1;
        logic [1:0]    rr;
        logic [DW-1:0] gr;
        logic [1:0]    eRqr;
        logic [1:0]    eRsv;
        logic          eWe;
        logic          eRe;
        logic [DW-1:0] eGpw;
        logic [DW-1:0] eRd;
        logic          eBusy;
        logic          eOwn;
    } vec_t;

    vec_t vecs[16];

    // Reference model: tracks each transaction by its age in cycles since
    // acceptance and derives strobes/responses from the documented timing.
    bit            mActive[2];
    int            mAge[2];
    bit            mOwner[2];
    bit            mPrio[2];
    bit            mWrite[2];
    logic [DW-1:0] mWdata[2];
    logic [DW-1:0] mRdata[2];
    int            mLat[2];

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit pickReq(input logic [1:0] v, input bit prio);
        if (v == 2'b11) return prio;
        return (v == 2'b10);
    endfunction

    function automatic int respAge(input int d);
        return mWrite[d] ? 2 : 2 + mLat[d];
    endfunction

    task automatic modelReset(input int d);
        mActive[d] = 1'b0;
        mAge[d]    = 0;
        mOwner[d]  = 1'b0;
        mPrio[d]   = 1'b0;
        mWrite[d]  = 1'b0;
        mWdata[d]  = '0;
        mRdata[d]  = '0;
    endtask

    task automatic modelCheck(input int d);
        logic [1:0] eRqr;
        logic [1:0] eRsv;
        logic       eWe;
        logic       eRe;
        bit         g;
        eRqr = 2'b00;
        eRsv = 2'b00;
        eWe  = 1'b0;
        eRe  = 1'b0;
        if (!mActive[d]) begin
            if (rqValid[d] != 2'b00) begin
                g    = pickReq(rqValid[d], mPrio[d]);
                eRqr = g ? 2'b10 : 2'b01;
            end
        end else begin
            if (mAge[d] == 1) begin
                eWe = mWrite[d];
                eRe = !mWrite[d];
            end
            if (mAge[d] >= respAge(d)) eRsv = mOwner[d] ? 2'b10 : 2'b01;
        end
        checkOutput($sformatf("d%0d_rq_ready", d), rqReadyO[d], eRqr);
        checkOutput($sformatf("d%0d_rsp_valid", d), rspValidO[d], eRsv);
        checkOutput($sformatf("d%0d_gp_we", d), gpWeO[d], eWe);
        checkOutput($sformatf("d%0d_gp_re", d), gpReO[d], eRe);
        checkOutput($sformatf("d%0d_gp_wdata", d), gpWdataO[d], mWdata[d]);
        checkOutput($sformatf("d%0d_busy", d), busyO[d], mActive[d]);
        checkOutput($sformatf("d%0d_owner", d), ownerO[d], mOwner[d]);
        if (eRsv != 2'b00) checkOutput($sformatf("d%0d_rsp_rdata", d), rspRdataO[d], mRdata[d]);
    endtask

    task automatic modelUpdate(input int d);
        bit g;
        if (!mActive[d]) begin
            if (rqValid[d] != 2'b00) begin
                g          = pickReq(rqValid[d], mPrio[d]);
                mActive[d] = 1'b1;
                mAge[d]    = 1;
                mOwner[d]  = g;
                mPrio[d]   = !g;
                mWrite[d]  = rqWrite[d][g];
                if (mWrite[d]) mWdata[d] = g ? rqWdata[d][2*DW-1:DW] : rqWdata[d][DW-1:0];
            end
        end else if (mAge[d] >= respAge(d)) begin
            if (rspReady[d][mOwner[d]]) mActive[d] = 1'b0;
        end else begin
            if (mWrite[d]) mRdata[d] = '0;
            else if (mAge[d] == 1 + mLat[d]) mRdata[d] = gpRdata[d];
            mAge[d]++;
        end
    endtask

    task automatic clearInputs();
        rqValid  = '0;
        rqWrite  = '0;
        rspReady = '0;
        rqWdata  = '0;
        gpRdata  = '0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        clearInputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        modelReset(0);
        modelReset(1);
    endtask

    task automatic applyStimulus(input vec_t v);
        rqValid[0]  = v.v;
        rqWrite[0]  = v.w;
        rqWdata[0]  = {v.wd1, v.wd0};
        rspReady[0] = v.rr;
        gpRdata[0]  = v.gr;
    endtask

    task automatic checkVector(input vec_t v, input int i);
        checkOutput($sformatf("vec%0d_rq_ready", i), rqReadyO[0], v.eRqr);
        checkOutput($sformatf("vec%0d_rsp_valid", i), rspValidO[0], v.eRsv);
        checkOutput($sformatf("vec%0d_gp_we", i), gpWeO[0], v.eWe);
        checkOutput($sformatf("vec%0d_gp_re", i), gpReO[0], v.eRe);
        checkOutput($sformatf("vec%0d_gp_wdata", i), gpWdataO[0], v.eGpw);
        checkOutput($sformatf("vec%0d_busy", i), busyO[0], v.eBusy);
        checkOutput($sformatf("vec%0d_owner", i), ownerO[0], v.eOwn);
        if (v.eRsv != 2'b00) checkOutput($sformatf("vec%0d_rsp_rdata", i), rspRdataO[0], v.eRd);
    endtask

    task automatic driveRandom(input int d);
        for (int i = 0; i < 2; i++) begin
            if (!(rqValid[d][i] && !lastReady[d][i] && $urandom_range(0, 15) != 0)) begin
                rqValid[d][i]            = ($urandom_range(0, 2) != 0);
                rqWrite[d][i]            = 1'($urandom_range(0, 1));
                rqWdata[d][i*DW +: DW]   = $urandom;
            end
        end
        rspReady[d] = 2'($urandom_range(0, 3));
        gpRdata[d]  = $urandom;
    endtask

    // Directed vectors for the RD_LAT=1 instance: a write from requester 0,
    // a read from requester 1 with a stalled response, then a write from 0.
    task automatic loadVectors();
        logic [DW-1:0] a5;
        logic [DW-1:0] rd;
        logic [DW-1:0] db;
        a5 = 32'hA5A5A5A5;
        rd = 32'h12345678;
        db = 32'hDEADBEEF;
        vecs[0]  = '{2'b00, 2'b00, '0,    '0, 2'b11, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0,    '0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 2'b01, a5,    '0, 2'b11, '0, 2'b01, 2'b00, 1'b0, 1'b0, '0,    '0, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 2'b00, '0,    '0, 2'b11, '0, 2'b00, 2'b00, 1'b1, 1'b0, a5,    '0, 1'b1, 1'b0};
        vecs[3]  = '{2'b00, 2'b00, '0,    '0, 2'b11, '0, 2'b00, 2'b01, 1'b0, 1'b0, a5,    '0, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 2'b00, '0,    '0, 2'b11, '0, 2'b10, 2'b00, 1'b0, 1'b0, a5,    '0, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 2'b00, '0,    '0, 2'b11, '0, 2'b00, 2'b00, 1'b0, 1'b1, a5,    '0, 1'b1, 1'b1};
        vecs[6]  = '{2'b00, 2'b00, '0,    '0, 2'b11, rd, 2'b00, 2'b00, 1'b0, 1'b0, a5,    '0, 1'b1, 1'b1};
        vecs[7]  = '{2'b01, 2'b01, 32'h55, '0, 2'b00, db, 2'b00, 2'b10, 1'b0, 1'b0, a5,   rd, 1'b1, 1'b1};
        vecs[8]  = '{2'b01, 2'b01, 32'h55, '0, 2'b01, db, 2'b00, 2'b10, 1'b0, 1'b0, a5,   rd, 1'b1, 1'b1};
        vecs[9]  = '{2'b01, 2'b01, 32'h55, '0, 2'b00, db, 2'b00, 2'b10, 1'b0, 1'b0, a5,   rd, 1'b1, 1'b1};
        vecs[10] = '{2'b01, 2'b01, 32'h55, '0, 2'b10, db, 2'b00, 2'b10, 1'b0, 1'b0, a5,   rd, 1'b1, 1'b1};
        vecs[11] = '{2'b01, 2'b01, 32'h55, '0, 2'b00, db, 2'b01, 2'b00, 1'b0, 1'b0, a5,   '0, 1'b0, 1'b1};
        vecs[12] = '{2'b00, 2'b00, '0,    '0, 2'b00, db, 2'b00, 2'b00, 1'b1, 1'b0, 32'h55, '0, 1'b1, 1'b0};
        vecs[13] = '{2'b00, 2'b00, '0,    '0, 2'b00, db, 2'b00, 2'b01, 1'b0, 1'b0, 32'h55, '0, 1'b1, 1'b0};
        vecs[14] = '{2'b00, 2'b00, '0,    '0, 2'b01, db, 2'b00, 2'b01, 1'b0, 1'b0, 32'h55, '0, 1'b1, 1'b0};
        vecs[15] = '{2'b00, 2'b00, '0,    '0, 2'b00, db, 2'b00, 2'b00, 1'b0, 1'b0, 32'h55, '0, 1'b0, 1'b0};
    endtask

    // Main test sequence.
    initial begin
        int            n0;
        int            n1;
        int            seen;
        logic [1:0]    rdy;
        logic [DW-1:0] fairData[8];
        logic          fairOwn[8];
        logic [DW-1:0] fairExp;

        mLat[0] = 1;
        mLat[1] = 3;
        lastReady = '0;
        rstN = 1'b0;
        clearInputs();
        loadVectors();

        // Reset state, with requests pending that must not be acknowledged.
        rqValid[0] = 2'b11;
        rqValid[1] = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst%0d_rq_ready", d), rqReadyO[d], 2'b00);
            checkOutput($sformatf("rst%0d_rsp_valid", d), rspValidO[d], 2'b00);
            checkOutput($sformatf("rst%0d_rsp_rdata", d), rspRdataO[d], '0);
            checkOutput($sformatf("rst%0d_gp_wdata", d), gpWdataO[d], '0);
            checkOutput($sformatf("rst%0d_strobes", d), {gpWeO[d], gpReO[d]}, 2'b00);
            checkOutput($sformatf("rst%0d_busy", d), busyO[d], 1'b0);
            checkOutput($sformatf("rst%0d_owner", d), ownerO[d], 1'b0);
        end
        doReset();

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(vecs[i], i);
            @(posedge clk);
            #1;
        end

        // Fairness: both requesters continuously valid with four writes each.
        doReset();
        n0 = 0;
        n1 = 0;
        seen = 0;
        rqWrite[0]  = 2'b11;
        rspReady[0] = 2'b11;
        for (int c = 0; c < 60 && seen < 8; c++) begin
            rqValid[0] = {(n1 < 4), (n0 < 4)};
            rqWdata[0] = {DW'(32'h11 + n1), DW'(1 + n0)};
            @(negedge clk);
            rdy = rqReadyO[0];
            if (gpWeO[0]) begin
                if (seen < 8) begin
                    fairData[seen] = gpWdataO[0];
                    fairOwn[seen]  = ownerO[0];
                end
                seen++;
            end
            @(posedge clk);
            #1;
            if (rdy[0]) n0++;
            if (rdy[1]) n1++;
        end
        checkOutput("fair_count", seen, 8);
        for (int k = 0; k < 8 && k < seen; k++) begin
            fairExp = (k % 2 == 0) ? DW'(k / 2 + 1) : DW'(32'h11 + k / 2);
            checkOutput($sformatf("fair_data%0d", k), fairData[k], fairExp);
            checkOutput($sformatf("fair_owner%0d", k), fairOwn[k], DW'(k % 2));
        end

        // RD_LAT=3: response appears in T+5 carrying the value present in T+4.
        doReset();
        rqValid[1]  = 2'b10;
        rqWrite[1]  = 2'b00;
        rspReady[1] = 2'b10;
        @(negedge clk);
        checkOutput("lat3_rq_ready", rqReadyO[1], 2'b10);
        @(posedge clk);
        #1;
        rqValid[1] = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            gpRdata[1] = DW'(k) * 32'h11111111;
            @(negedge clk);
            if (k == 1) checkOutput("lat3_gp_re", gpReO[1], 1'b1);
            if (k == 4) checkOutput("lat3_no_early_rsp", rspValidO[1], 2'b00);
            if (k == 5) begin
                checkOutput("lat3_rsp_valid", rspValidO[1], 2'b10);
                checkOutput("lat3_rsp_rdata", rspRdataO[1], 32'h44444444);
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted during WAIT: outputs drop at once, priority restarts.
        doReset();
        rqValid[1]  = 2'b01;
        rqWrite[1]  = 2'b00;
        rspReady[1] = 2'b11;
        @(negedge clk);
        checkOutput("rstw_grant", rqReadyO[1], 2'b01);
        @(posedge clk);
        #1;
        rqValid[1] = 2'b00;
        @(negedge clk);
        checkOutput("rstw_issue_re", gpReO[1], 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstw_busy_before", busyO[1], 1'b1);
        #2;
        rstN = 1'b0;
        rqValid[1] = 2'b11;
        #1;
        checkOutput("rstw_busy_async", busyO[1], 1'b0);
        checkOutput("rstw_rsp_valid_async", rspValidO[1], 2'b00);
        checkOutput("rstw_strobes_async", {gpWeO[1], gpReO[1]}, 2'b00);
        checkOutput("rstw_rq_ready_in_reset", rqReadyO[1], 2'b00);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        rqValid[1] = 2'b00;
        @(negedge clk);
        checkOutput("rstw_after_busy", busyO[1], 1'b0);
        checkOutput("rstw_after_rsp", rspValidO[1], 2'b00);
        checkOutput("rstw_after_re", gpReO[1], 1'b0);
        @(posedge clk);
        #1;
        rqValid[1] = 2'b11;
        rqWrite[1] = 2'b11;
        @(negedge clk);
        checkOutput("rstw_tie_to_req0", rqReadyO[1], 2'b01);
        @(posedge clk);
        #1;

        // Randomized traffic on both instances against the reference model.
        doReset();
        lastReady = '0;
        for (int c = 0; c < 3000; c++) begin
            driveRandom(0);
            driveRandom(1);
            @(negedge clk);
            modelCheck(0);
            modelCheck(1);
            lastReady = rqReadyO;
            @(posedge clk);
            modelUpdate(0);
            modelUpdate(1);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/gpio_arbiter.md
# gpio_arbiter

Two-port round-robin arbiter and access sequencer for the GPIO register block. Two independent requesters (e.g. CPU bus bridge and a pattern/DMA engine) issue single-word read or write commands over valid/ready handshakes. The arbiter serialises them onto the GPIO's single `we`/`re`/`data_in`/`data_out` port, enforcing the GPIO read latency, and returns a response to the owning requester only.

## Interface
- `DW`, 32, data width of GPIO register and requester data
- `RD_LAT`, 1, cycles from `gp_re` high until `gp_rdata` is valid (1..15)
- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low
- `rq_valid` in 2, command valid, bit i = requester i
- `rq_write` in 2, 1 = write, 0 = read, per requester
- `rq_wdata` in 2*DW, write data; requester i at `[i*DW +: DW]`
- `rq_ready` out 2, command accepted (one-hot or zero)
- `rsp_valid` out 2, response valid to owner (one-hot or zero)
- `rsp_ready` in 2, requester accepts response
- `rsp_rdata` out DW, read data (0 for write responses), shared by both
- `gp_we` out 1, to GPIO `we`
- `gp_re` out 1, to GPIO `re`
- `gp_wdata` out DW, to GPIO `data_in`
- `gp_rdata` in DW, from GPIO `data_out`
- `busy` out 1, high in any state other than IDLE
- `owner` out 1, index of requester currently/last granted

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `rq_valid`, grant one requester: if both valid, grant `prio`; else grant the one valid. `rq_ready[g]` asserted combinationally that cycle; command (`rq_write[g]`, its wdata) latched, `owner<=g`, `prio<=~g`. Go to ISSUE.
- ISSUE (exactly 1 cycle): `gp_we=1` for write or `gp_re=1` for read; `gp_wdata` = latched wdata. Write -> RESP with `rsp_rdata=0`. Read -> WAIT with counter loaded to `RD_LAT`.
- WAIT: counter decrements each cycle; on the cycle counter reaches 1, `gp_rdata` captured into `rsp_rdata`; -> RESP.
- RESP: `rsp_valid[owner]=1`, held with `rsp_rdata` stable until `rsp_ready[owner]`; then -> IDLE. `rsp_ready` of non-owner ignored.
- No new command accepted before the previous response is taken (one outstanding transaction).
- Requesters hold `rq_valid`/`rq_write`/`rq_wdata` stable until `rq_ready`; deasserting `rq_valid` before grant is legal and simply withdraws the request.
- `gp_we`, `gp_re` never high together; never high outside ISSUE.
- `gp_wdata` holds last latched write data between transactions (reads do not change it).

## Timing
- Reset (async, `reset=0`): state IDLE, `prio=0`, `owner=0`, `rq_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `gp_we=0`, `gp_re=0`, `gp_wdata=0`, `busy=0`, counter 0. Outputs clear immediately, not at next edge.
- Reset mid-transaction: transaction dropped, no response, no further GPIO strobe; after release, arbitration restarts with `prio=0`.
- Accept in cycle T: `gp_we`/`gp_re` high in cycle T+1.
- Write: `rsp_valid` first high in T+2.
- Read: `gp_rdata` sampled at end of cycle T+1+RD_LAT; `rsp_valid` first high in T+2+RD_LAT.
- Response taken in cycle R (`rsp_valid&rsp_ready`): IDLE in R+1; earliest next accept R+1.
- Back-to-back minimum: write 3 cycles, read 3+RD_LAT cycles per transaction (with `rsp_ready` held high).
- Fairness: with both requesters continuously valid, grants strictly alternate; first grant after reset goes to requester 0.

## Test plan
- Requester 0 write 32'hA5A5A5A5, `rsp_ready=1` -> `rq_ready[0]` in T, `gp_we=1`/`gp_wdata=A5A5A5A5` in T+1 only, `rsp_valid[0]` in T+2 with `rsp_rdata=0`, `gp_re` never high.
- Requester 1 read, GPIO returns 32'h12345678, RD_LAT=1 -> `gp_re` in T+1 only, `rsp_valid[1]` in T+3 with `rsp_rdata=12345678`; `rsp_valid[0]` stays 0.
- Both valid continuously after reset, 4 writes each (0x1..0x4 / 0x11..0x14) -> GPIO sees 0x1,0x11,0x2,0x12,... strictly alternating; `owner` toggles per grant.
- Read with `rsp_ready` low for 3 cycles, `gp_rdata` changed to 32'hDEADBEEF after capture -> `rsp_valid` held 4 cycles, `rsp_rdata` stays 12345678; no new `rq_ready` until taken.
- RD_LAT=3 read -> `rsp_valid` in T+5, captures value present in T+4, not earlier/later values.
- `reset` driven low during WAIT -> `busy`, `rsp_valid`, `gp_re` drop asynchronously; after release, next request from requester 1 alone granted normally, first arbitration tie goes to requester 0.
